// File: rtl/button_debouncer_if.sv
// Signal bundle between the debouncer and whatever drives its sample tick and
// button input. The master side drives the inputs; the slave side is the debouncer.
interface button_debouncer_if;
    logic tick_in;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic sample_strobe;

    modport master (
        output tick_in,
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  sample_strobe
    );

    modport slave (
        input  tick_in,
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output sample_strobe
    );
endinterface

// File: rtl/button_debouncer.sv
// Button debouncer: synchronises a raw mechanical input, samples it on each
// rising edge of a slow divider tick, and flips the clean level only after
// STABLE_COUNT consecutive samples disagree with it. Emits one-cycle
// press/release strobes on each flip.
module button_debouncer #(
    parameter int unsigned STABLE_COUNT = 4,  // 1..255
    parameter int unsigned SYNC_STAGES  = 2   // 2..4
) (
    input logic               clk,
    input logic               reset,
    button_debouncer_if.slave btn_if
);

    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] PEND_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] PEND_LOW  = 2'd3;

    // Count value on which the next agreeing sample completes the flip.
    localparam logic [7:0] CNT_LAST = 8'(STABLE_COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;
    logic                   tick_prev_q;
    logic                   sample_en;
    logic [1:0]             state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   strobe_q;

    assign btn_sync  = sync_q[SYNC_STAGES-1];
    assign sample_en = btn_if.tick_in & ~tick_prev_q;

    // Synchroniser chain and tick edge detector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            tick_prev_q <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], btn_if.btn_in};
            tick_prev_q <= btn_if.tick_in;
            strobe_q    <= sample_en;
        end
    end

    // Debounce FSM next state; everything holds unless a sample edge is present.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sample_en) begin
            case (state_q)
                IDLE_LOW: begin
                    if (btn_sync) begin
                        if (STABLE_COUNT == 1) begin
                            state_d = IDLE_HIGH;
                            level_d = 1'b1;
                            press_d = 1'b1;
                        end else begin
                            state_d = PEND_HIGH;
                            cnt_d   = 8'd1;
                        end
                    end
                end
                PEND_HIGH: begin
                    if (!btn_sync) begin
                        // Glitch: back to idle, count discarded.
                        state_d = IDLE_LOW;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE_HIGH;
                        cnt_d   = 8'd0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                IDLE_HIGH: begin
                    if (!btn_sync) begin
                        if (STABLE_COUNT == 1) begin
                            state_d   = IDLE_LOW;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                        end else begin
                            state_d = PEND_LOW;
                            cnt_d   = 8'd1;
                        end
                    end
                end
                PEND_LOW: begin
                    if (btn_sync) begin
                        state_d = IDLE_HIGH;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE_LOW;
                        cnt_d     = 8'd0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE_LOW;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // FSM state, counter, level and strobe registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE_LOW;
            cnt_q     <= 8'd0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_if.btn_level     = level_q;
    assign btn_if.btn_press     = press_q;
    assign btn_if.btn_release   = release_q;
    assign btn_if.sample_strobe = strobe_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: unit 0 uses STABLE_COUNT=4, unit 1 STABLE_COUNT=1.
// Tick toggles every 5 clocks; its rising edge is driven after step n with
// n%10==5, so the debouncer acts on the edge that ends step n+1 (n+1 % 10 == 6).
module tb_button_debouncer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    button_debouncer_if bif0 ();
    button_debouncer_if bif1 ();

    button_debouncer #(
        .STABLE_COUNT(4),
        .SYNC_STAGES (2)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .btn_if(bif0.slave)
    );

    button_debouncer #(
        .STABLE_COUNT(1),
        .SYNC_STAGES (2)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .btn_if(bif1.slave)
    );

    typedef struct {
        int         cyc;
        int         unit;
        logic [2:0] exp;  // {level, press, release}
        string      name;
    } exp_t;

    typedef struct {
        logic  btn;
        int    samples;
        logic  flip;
        string name;
    } vec_t;

    exp_t sb[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   tick_mode  = 0;  // 0: free-running, 1: held high
    int   press_cnt  [2];
    int   rel_cnt    [2];
    int   strobe_cnt [2];

    function automatic vec_t mk_vec(logic b, int s, logic f, string n);
        vec_t v;
        v.btn     = b;
        v.samples = s;
        v.flip    = f;
        v.name    = n;
        return v;
    endfunction

    // First step >= from on whose closing edge the DUT takes a sample.
    function automatic int first_act(int from);
        int m;
        m = from;
        while (m % 10 != 6) m++;
        return m;
    endfunction

    task automatic expect_at(int c, int unit, logic lvl, logic pr, logic rl, string name);
        exp_t e;
        e.cyc  = c;
        e.unit = unit;
        e.exp  = {lvl, pr, rl};
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic expect_flip(int unit, int m, logic new_lvl, string name);
        expect_at(m - 1, unit, ~new_lvl, 1'b0, 1'b0, {name, "_before"});
        expect_at(m, unit, new_lvl, new_lvl, ~new_lvl, {name, "_flip"});
        expect_at(m + 1, unit, new_lvl, 1'b0, 1'b0, {name, "_after"});
    endtask

    task automatic check_int(string name, int got, int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic check_bits(string name, logic [3:0] got, logic [3:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, pop due expectations,
    // then drive the next tick value.
    task automatic step();
        exp_t       e;
        logic [2:0] act;
        logic       t;
        @(posedge clk);
        #1;
        cyc++;
        if (bif0.btn_press === 1'b1)     press_cnt[0]++;
        if (bif1.btn_press === 1'b1)     press_cnt[1]++;
        if (bif0.btn_release === 1'b1)   rel_cnt[0]++;
        if (bif1.btn_release === 1'b1)   rel_cnt[1]++;
        if (bif0.sample_strobe === 1'b1) strobe_cnt[0]++;
        if (bif1.sample_strobe === 1'b1) strobe_cnt[1]++;
        checks++;
        if ((bif0.btn_press & bif0.btn_release) !== 1'b0 ||
            (bif1.btn_press & bif1.btn_release) !== 1'b0) begin
            failures++;
            $display("FAIL strobe_exclusive cyc=%0d got press&release high, want never", cyc);
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = (e.unit == 0) ? {bif0.btn_level, bif0.btn_press, bif0.btn_release}
                                : {bif1.btn_level, bif1.btn_press, bif1.btn_release};
            checks++;
            if (e.cyc != cyc || act !== e.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d got lvl/press/rel=%b want %b (due cyc %0d)",
                         e.name, cyc, act, e.exp, e.cyc);
            end
        end
        t = (tick_mode == 1) ? 1'b1 : ((cyc % 10) >= 5);
        bif0.tick_in = t;
        bif1.tick_in = t;
    endtask

    task automatic run_until(int target);
        while (cyc < target) step();
    endtask

    initial begin
        vec_t vecs[7];
        int   j, m1, mk, r;
        logic lvl;
        exp_t e;

        vecs[0] = mk_vec(1'b1, 3, 1'b0, "bounce_hi3");
        vecs[1] = mk_vec(1'b1, 4, 1'b1, "press");
        vecs[2] = mk_vec(1'b0, 2, 1'b0, "bounce_lo2");
        vecs[3] = mk_vec(1'b0, 4, 1'b1, "release");
        vecs[4] = mk_vec(1'b1, 1, 1'b0, "bounce_hi1");
        vecs[5] = mk_vec(1'b1, 4, 1'b1, "press2");
        vecs[6] = mk_vec(1'b0, 4, 1'b1, "release2");

        for (int u = 0; u < 2; u++) begin
            press_cnt[u]  = 0;
            rel_cnt[u]    = 0;
            strobe_cnt[u] = 0;
        end

        reset        = 1'b1;
        bif0.btn_in  = 1'b0;
        bif1.btn_in  = 1'b0;
        bif0.tick_in = 1'b0;
        bif1.tick_in = 1'b0;
        repeat (3) step();
        check_bits("reset_u0", {bif0.btn_level, bif0.btn_press, bif0.btn_release,
                                bif0.sample_strobe}, 4'b0000);
        check_bits("reset_u1", {bif1.btn_level, bif1.btn_press, bif1.btn_release,
                                bif1.sample_strobe}, 4'b0000);
        reset = 1'b0;
        lvl   = 1'b0;
        run_until(cyc + 20);

        // Table-driven press / release / bounce vectors on unit 0.
        for (int i = 0; i < 7; i++) begin
            press_cnt[0] = 0;
            rel_cnt[0]   = 0;
            j            = cyc;
            bif0.btn_in  = vecs[i].btn;
            m1           = first_act(j + 3);
            mk           = m1 + 30;
            if (vecs[i].flip) begin
                expect_flip(0, mk, vecs[i].btn, vecs[i].name);
                lvl = vecs[i].btn;
            end else begin
                run_until(m1 + 10 * (vecs[i].samples - 1));
                bif0.btn_in = ~vecs[i].btn;
                expect_at(mk, 0, lvl, 1'b0, 1'b0, {vecs[i].name, "_hold"});
                expect_at(mk + 1, 0, lvl, 1'b0, 1'b0, {vecs[i].name, "_hold2"});
            end
            run_until(mk + 8);
            check_int({vecs[i].name, "_press_cnt"}, press_cnt[0],
                      (vecs[i].flip && vecs[i].btn) ? 1 : 0);
            check_int({vecs[i].name, "_release_cnt"}, rel_cnt[0],
                      (vecs[i].flip && !vecs[i].btn) ? 1 : 0);
        end

        // Tick held high: a single sample edge, nothing else happens.
        while (cyc % 10 != 2) step();
        tick_mode     = 1;
        bif0.tick_in  = 1'b1;
        bif1.tick_in  = 1'b1;
        strobe_cnt[0] = 0;
        press_cnt[0]  = 0;
        rel_cnt[0]    = 0;
        run_until(cyc + 60);
        check_int("idle_tick_strobes", strobe_cnt[0], 1);
        check_bits("idle_tick_outputs", {bif0.btn_level, press_cnt[0] != 0, rel_cnt[0] != 0,
                                         bif0.sample_strobe}, 4'b0000);
        while (cyc % 10 != 0) step();
        tick_mode    = 0;
        bif0.tick_in = 1'b0;
        bif1.tick_in = 1'b0;
        run_until(cyc + 10);

        // Asynchronous reset in PEND_HIGH with cnt=2, then a fresh 4-sample press.
        j           = cyc;
        bif0.btn_in = 1'b1;
        m1          = first_act(j + 3);
        run_until(m1 + 10);
        check_int("strobe_at_sample", int'(bif0.sample_strobe), 1);
        #2;
        reset = 1'b1;
        #1;
        check_bits("reset_async_u0", {bif0.btn_level, bif0.btn_press, bif0.btn_release,
                                      bif0.sample_strobe}, 4'b0000);
        repeat (3) step();
        reset        = 1'b0;
        r            = cyc;
        mk           = first_act(r + 3) + 30;
        press_cnt[0] = 0;
        expect_flip(0, mk, 1'b1, "post_reset_press");
        run_until(mk + 5);
        check_int("post_reset_press_cnt", press_cnt[0], 1);

        // STABLE_COUNT=1: flip on the first disagreeing sample.
        press_cnt[1] = 0;
        rel_cnt[1]   = 0;
        j            = cyc;
        bif1.btn_in  = 1'b1;
        m1           = first_act(j + 3);
        expect_flip(1, m1, 1'b1, "sc1_press");
        run_until(m1 + 5);
        check_int("sc1_press_cnt", press_cnt[1], 1);
        j           = cyc;
        bif1.btn_in = 1'b0;
        m1          = first_act(j + 3);
        expect_flip(1, m1, 1'b0, "sc1_release");
        run_until(m1 + 5);
        check_int("sc1_release_cnt", rel_cnt[1], 1);

        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL %s never compared got=none want %b (due cyc %0d)", e.name, e.exp,
                     e.cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
